// File: rtl/tmp2_target_if.sv
// I2C pin bundle for the TMP2 target: SCL/SDA inputs from the bus and the
// open-drain SDA drive pair.
// Open-drain semantics: SDA_t=1 releases the line, SDA_t=0 drives SDA_o (always 0)
// onto it; there is no valid/ready handshake, SCL edges pace every transfer.
interface tmp2_target_if;
  logic SCL_i;
  logic SDA_i;
  logic SDA_o;
  logic SDA_t;

  modport slave (input SCL_i, input SDA_i, output SDA_o, output SDA_t);
  modport master (output SCL_i, output SDA_i, input SDA_o, input SDA_t);
endinterface

// File: rtl/tmp2_target.sv
// I2C target emulating a TMP-style temperature sensor register file (address 10010xx).
// Optional macro TMP2_TARGET_GLITCH_FILTER_EN adds a 3-sample majority filter on SCL/SDA.
module tmp2_target (
  input  logic               clk,
  input  logic               rst,
  tmp2_target_if.slave       i2c,
  input  logic [1:0]         address_bits,
  input  logic [15:0]        temperature_i,
  output logic [7:0]         config_o,
  output logic [15:0]        t_high_o,
  output logic [15:0]        t_low_o,
  output logic [15:0]        t_crit_o,
  output logic [7:0]         t_hyst_o,
  output logic               write_o,
  output logic               sw_rst_o,
  output logic               busy,
  output logic [2:0]         dbg_state_o,
  output logic [7:0]         dbg_ptr_o
);

  localparam logic [7:0]  CFG_DEF  = 8'h00;
  localparam logic [15:0] HIGH_DEF = 16'h2000;
  localparam logic [15:0] LOW_DEF  = 16'h0500;
  localparam logic [15:0] CRIT_DEF = 16'h4980;
  localparam logic [7:0]  HYST_DEF = 8'h05;
  localparam logic [7:0]  SW_RST_PTR = 8'h2F;

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
  } state_t;

  logic scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;
  logic scl_prev_q, sda_prev_q;
  logic scl_line, sda_line;

  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
    end else begin
      scl_s1_q <= i2c.SCL_i;
      scl_s2_q <= scl_s1_q;
      sda_s1_q <= i2c.SDA_i;
      sda_s2_q <= sda_s1_q;
    end
  end

`ifdef TMP2_TARGET_GLITCH_FILTER_EN
  logic [1:0] scl_h_q, sda_h_q;
  logic       scl_f_q, sda_f_q;

  // Majority of the current and two previous samples, registered: +2 cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_h_q <= 2'b11;
      sda_h_q <= 2'b11;
      scl_f_q <= 1'b1;
      sda_f_q <= 1'b1;
    end else begin
      scl_h_q <= {scl_h_q[0], scl_s2_q};
      sda_h_q <= {sda_h_q[0], sda_s2_q};
      scl_f_q <= (scl_s2_q & scl_h_q[0]) | (scl_s2_q & scl_h_q[1]) | (scl_h_q[0] & scl_h_q[1]);
      sda_f_q <= (sda_s2_q & sda_h_q[0]) | (sda_s2_q & sda_h_q[1]) | (sda_h_q[0] & sda_h_q[1]);
    end
  end

  assign scl_line = scl_f_q;
  assign sda_line = sda_f_q;
`else
  assign scl_line = scl_s2_q;
  assign sda_line = sda_s2_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_line;
      sda_prev_q <= sda_line;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_line & ~scl_prev_q;
  assign scl_fall  = ~scl_line & scl_prev_q;
  assign start_det = scl_line & scl_prev_q & ~sda_line & sda_prev_q;
  assign stop_det  = scl_line & scl_prev_q & sda_line & ~sda_prev_q;

  state_t      state_q;
  logic [3:0]  bit_cnt_q;
  logic [6:0]  shift_q;
  logic [7:0]  tx_q;
  logic [7:0]  ptr_q;
  logic        ptr_phase_q;
  logic        rw_q;
  logic        ack_on_q;
  logic        sda_t_q;
  logic        busy_q;
  logic        write_q;
  logic        sw_rst_q;
  logic [15:0] snap_q;
  logic [7:0]  config_q;
  logic [15:0] t_high_q, t_low_q, t_crit_q;
  logic [7:0]  t_hyst_q;

  function automatic logic [7:0] reg_rd(input logic [7:0] p);
    case (p)
      8'h00:   reg_rd = snap_q[15:8];
      8'h01:   reg_rd = snap_q[7:0];
      8'h03:   reg_rd = config_q;
      8'h04:   reg_rd = t_high_q[15:8];
      8'h05:   reg_rd = t_high_q[7:0];
      8'h06:   reg_rd = t_low_q[15:8];
      8'h07:   reg_rd = t_low_q[7:0];
      8'h08:   reg_rd = t_crit_q[15:8];
      8'h09:   reg_rd = t_crit_q[7:0];
      8'h0A:   reg_rd = t_hyst_q;
      8'h0B:   reg_rd = 8'hCB;
      default: reg_rd = 8'h00;
    endcase
  endfunction

  logic [7:0] rx_byte, rd_cur, rd_nxt;
  logic       addr_match;
  assign rx_byte    = {shift_q, sda_line};
  assign addr_match = (rx_byte[7:1] == {5'b10010, address_bits});
  assign rd_cur     = reg_rd(ptr_q);
  assign rd_nxt     = reg_rd(ptr_q + 8'd1);

  always_ff @(posedge clk) begin
    write_q  <= 1'b0;
    sw_rst_q <= 1'b0;
    if (!rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 7'd0;
      tx_q        <= 8'd0;
      ptr_q       <= 8'h00;
      ptr_phase_q <= 1'b0;
      rw_q        <= 1'b0;
      ack_on_q    <= 1'b0;
      sda_t_q     <= 1'b1;
      busy_q      <= 1'b0;
      snap_q      <= 16'h0000;
      config_q    <= CFG_DEF;
      t_high_q    <= HIGH_DEF;
      t_low_q     <= LOW_DEF;
      t_crit_q    <= CRIT_DEF;
      t_hyst_q    <= HYST_DEF;
    end else if (stop_det) begin
      state_q <= IDLE;
      sda_t_q <= 1'b1;
      busy_q  <= 1'b0;
    end else if (start_det) begin
      state_q   <= ADDR;
      bit_cnt_q <= 4'd0;
      sda_t_q   <= 1'b1;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          shift_q   <= rx_byte[6:0];
          bit_cnt_q <= bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_q <= 4'd0;
            ack_on_q  <= 1'b0;
            if (addr_match) begin
              rw_q    <= sda_line;
              state_q <= ADDR_ACK;
              if (sda_line) snap_q <= temperature_i;
            end else begin
              state_q <= IGNORE;
            end
          end
        end
        // First fall after bit 8 pulls SDA low; the next one ends the ACK slot.
        ADDR_ACK: if (scl_fall) begin
          if (!ack_on_q) begin
            sda_t_q  <= 1'b0;
            ack_on_q <= 1'b1;
          end else if (rw_q) begin
            state_q   <= RD_BYTE;
            tx_q      <= {rd_cur[6:0], 1'b0};
            sda_t_q   <= rd_cur[7];
            bit_cnt_q <= 4'd1;
          end else begin
            state_q     <= WR_BYTE;
            ptr_phase_q <= 1'b1;
            sda_t_q     <= 1'b1;
            bit_cnt_q   <= 4'd0;
          end
        end
        WR_BYTE: if (scl_rise) begin
          shift_q   <= rx_byte[6:0];
          bit_cnt_q <= bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_q <= 4'd0;
            ack_on_q  <= 1'b0;
            state_q   <= WR_ACK;
            if (ptr_phase_q) begin
              ptr_phase_q <= 1'b0;
              ptr_q       <= rx_byte;
              if (rx_byte == SW_RST_PTR) begin
                sw_rst_q <= 1'b1;
                config_q <= CFG_DEF;
                t_high_q <= HIGH_DEF;
                t_low_q  <= LOW_DEF;
                t_crit_q <= CRIT_DEF;
                t_hyst_q <= HYST_DEF;
              end
            end else begin
              ptr_q   <= ptr_q + 8'd1;
              write_q <= (ptr_q >= 8'h03) && (ptr_q <= 8'h0A);
              case (ptr_q)
                8'h03:   config_q       <= rx_byte;
                8'h04:   t_high_q[15:8] <= rx_byte;
                8'h05:   t_high_q[7:0]  <= rx_byte;
                8'h06:   t_low_q[15:8]  <= rx_byte;
                8'h07:   t_low_q[7:0]   <= rx_byte;
                8'h08:   t_crit_q[15:8] <= rx_byte;
                8'h09:   t_crit_q[7:0]  <= rx_byte;
                8'h0A:   t_hyst_q       <= rx_byte;
                default: ;
              endcase
            end
          end
        end
        WR_ACK: if (scl_fall) begin
          if (!ack_on_q) begin
            sda_t_q  <= 1'b0;
            ack_on_q <= 1'b1;
          end else begin
            sda_t_q <= 1'b1;
            state_q <= WR_BYTE;
          end
        end
        RD_BYTE: if (scl_fall) begin
          if (bit_cnt_q == 4'd8) begin
            sda_t_q <= 1'b1;
            state_q <= RD_ACK;
          end else begin
            sda_t_q   <= tx_q[7];
            tx_q      <= {tx_q[6:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
        end
        // Master NACK is seen on the rise; an ACK lets the next fall start the next byte.
        RD_ACK: begin
          if (scl_rise && sda_line) begin
            state_q <= IGNORE;
          end else if (scl_fall) begin
            ptr_q     <= ptr_q + 8'd1;
            tx_q      <= {rd_nxt[6:0], 1'b0};
            sda_t_q   <= rd_nxt[7];
            bit_cnt_q <= 4'd1;
            state_q   <= RD_BYTE;
          end
        end
        default: ;
      endcase
    end
  end

  assign i2c.SDA_o   = 1'b0;
  assign i2c.SDA_t   = sda_t_q;
  assign config_o    = config_q;
  assign t_high_o    = t_high_q;
  assign t_low_o     = t_low_q;
  assign t_crit_o    = t_crit_q;
  assign t_hyst_o    = t_hyst_q;
  assign write_o     = write_q;
  assign sw_rst_o    = sw_rst_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;
  assign dbg_ptr_o   = ptr_q;

endmodule

// File: tb/tb_tmp2_target.sv
// Bench for tmp2_target: bit-banged I2C master, byte-map reference model and
// an idle-window compare process.
module tb_tmp2_target;
  localparam int Q = 6;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [1:0]  address_bits;
  logic [15:0] temperature_i;
  logic [7:0]  config_o, t_hyst_o, dbg_ptr_o;
  logic [15:0] t_high_o, t_low_o, t_crit_o;
  logic        write_o, sw_rst_o, busy;
  logic [2:0]  dbg_state_o;
  logic        m_scl, m_sda;

  tmp2_target_if bus_if();
  assign bus_if.SCL_i = m_scl;
  assign bus_if.SDA_i = m_sda & (bus_if.SDA_t | bus_if.SDA_o);

  tmp2_target u_dut (
    .clk(clk), .rst(rst), .i2c(bus_if),
    .address_bits(address_bits), .temperature_i(temperature_i),
    .config_o(config_o), .t_high_o(t_high_o), .t_low_o(t_low_o),
    .t_crit_o(t_crit_o), .t_hyst_o(t_hyst_o), .write_o(write_o),
    .sw_rst_o(sw_rst_o), .busy(busy), .dbg_state_o(dbg_state_o),
    .dbg_ptr_o(dbg_ptr_o)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // reference model: byte image of the register map
  logic [7:0]  m_map [256];
  logic [7:0]  m_ptr;
  logic [15:0] m_snap;
  int          m_wr_cnt = 0;
  int          m_sw_cnt = 0;

  task automatic m_reset_regs();
    m_map[3] = 8'h00;
    m_map[4] = 8'h20; m_map[5] = 8'h00;
    m_map[6] = 8'h05; m_map[7] = 8'h00;
    m_map[8] = 8'h49; m_map[9] = 8'h80;
    m_map[10] = 8'h05;
  endtask

  task automatic m_reset_all();
    for (int i = 0; i < 256; i++) m_map[i] = 8'h00;
    m_map[11] = 8'hCB;
    m_reset_regs();
    m_ptr  = 8'h00;
    m_snap = 16'h0000;
  endtask

  function automatic bit m_writable(input logic [7:0] p);
    return (p >= 8'h03) && (p <= 8'h0A);
  endfunction

  function automatic logic [7:0] m_read(input logic [7:0] p);
    if (p == 8'h00) return m_snap[15:8];
    if (p == 8'h01) return m_snap[7:0];
    return m_map[p];
  endfunction

  // DUT monitors
  int d_wr_cnt = 0;
  int d_sw_cnt = 0;
  int sda_low = 0;
  always @(negedge clk) begin
    if (write_o) d_wr_cnt++;
    if (sw_rst_o) d_sw_cnt++;
    if (!bus_if.SDA_t) sda_low++;
  end

  // scoreboard compare process, active in quiet windows after each STOP
  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("config_o", config_o, m_map[3]);
      check("t_high_o", t_high_o, {m_map[4], m_map[5]});
      check("t_low_o", t_low_o, {m_map[6], m_map[7]});
      check("t_crit_o", t_crit_o, {m_map[8], m_map[9]});
      check("t_hyst_o", t_hyst_o, m_map[10]);
      check("pointer", dbg_ptr_o, m_ptr);
      check("busy_idle", busy, 1'b0);
      check("sda_t_idle", bus_if.SDA_t, 1'b1);
      check("write_count", d_wr_cnt, m_wr_cnt);
      check("swrst_count", d_sw_cnt, m_sw_cnt);
    end
  end

  // master driver tasks
  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic settle();
    repeat (12) @(negedge clk);
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b0;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wq(); m_scl = 1'b1; wq(); m_sda = 1'b0; wq(); m_scl = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wq(); m_scl = 1'b1; wq(); m_sda = 1'b1; wq();
  endtask

  task automatic wr_bit(input logic b);
    m_sda = b; wq(); m_scl = 1'b1; wq(); wq(); m_scl = 1'b0; wq();
  endtask

  task automatic rd_bit(output logic b);
    m_sda = 1'b1; wq(); m_scl = 1'b1; wq(); b = bus_if.SDA_i; wq(); m_scl = 1'b0; wq();
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack_n);
    for (int i = 7; i >= 0; i--) wr_bit(d[i]);
    rd_bit(ack_n);
  endtask

  task automatic recv_byte(output logic [7:0] d);
    logic bv;
    for (int i = 7; i >= 0; i--) begin
      rd_bit(bv);
      d[i] = bv;
    end
  endtask

  logic [7:0]  wr_q[$];
  logic [7:0]  rd_got[$];
  bit          change_temp = 1'b0;
  logic [15:0] temp_new;

  task automatic do_write(input logic [7:0] abyte, input bit stop);
    logic ackn;
    bit   match, first;
    match = (abyte[7:1] == {5'b10010, address_bits});
    i2c_start();
    send_byte(abyte, ackn);
    check("addr_ack_w", ackn, !match);
    check("busy_in_xfer", busy, 1'b1);
    first = 1'b1;
    foreach (wr_q[i]) begin
      send_byte(wr_q[i], ackn);
      check("data_ack", ackn, !match);
      if (match) begin
        if (first) begin
          m_ptr = wr_q[i];
          if (m_ptr == 8'h2F) begin
            m_reset_regs();
            m_sw_cnt++;
          end
          first = 1'b0;
        end else begin
          if (m_writable(m_ptr)) begin
            m_map[m_ptr] = wr_q[i];
            m_wr_cnt++;
          end
          m_ptr++;
        end
      end
    end
    if (stop) begin
      i2c_stop();
      settle();
    end
  endtask

  task automatic do_read(input logic [7:0] abyte, input int n);
    logic       ackn;
    logic [7:0] b;
    bit         match;
    match = (abyte[7:1] == {5'b10010, address_bits});
    rd_got.delete();
    i2c_start();
    send_byte(abyte, ackn);
    check("addr_ack_r", ackn, !match);
    if (match) begin
      m_snap = temperature_i;
      for (int i = 0; i < n; i++) begin
        recv_byte(b);
        rd_got.push_back(b);
        check("read_byte", b, m_read(m_ptr));
        if (i == 0 && change_temp) temperature_i = temp_new;
        if (i < n - 1) begin
          wr_bit(1'b0);
          m_ptr++;
        end else begin
          wr_bit(1'b1);
          check("sda_rel_nack", bus_if.SDA_t, 1'b1);
        end
      end
    end
    i2c_stop();
    settle();
  endtask

  function automatic logic [7:0] pick_ptr();
    int r;
    r = $urandom_range(0, 15);
    if (r < 12) return 8'(r);
    case (r)
      12: return 8'hFE;
      13: return 8'hFF;
      14: return 8'h2F;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic       bv, ackn;
    logic [1:0] a2;
    logic [7:0] abyte;
    int         sw0, kind, n;

    rst = 1'b0; m_scl = 1'b1; m_sda = 1'b1;
    address_bits = 2'b00; temperature_i = 16'h0000;
    m_reset_all();
    repeat (4) @(negedge clk);
    check("rst_sda_t", bus_if.SDA_t, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_write_o", write_o, 1'b0);
    check("rst_sw_rst_o", sw_rst_o, 1'b0);
    check("rst_config", config_o, 8'h00);
    check("rst_t_high", t_high_o, 16'h2000);
    check("rst_t_low", t_low_o, 16'h0500);
    check("rst_t_crit", t_crit_o, 16'h4980);
    check("rst_t_hyst", t_hyst_o, 8'h05);
    check("rst_ptr", dbg_ptr_o, 8'h00);
    rst = 1'b1;
    settle();

    // limit write with auto-increment
    address_bits = 2'b01;
    wr_q = '{8'h04, 8'h12, 8'h34};
    do_write(8'h92, 1'b1);
    check("t_high_1234", t_high_o, 16'h1234);
    check("two_writes", d_wr_cnt, 2);
    check("ptr_06", dbg_ptr_o, 8'h06);

    // pointer write, repeated START, two-byte temperature read
    address_bits = 2'b00;
    temperature_i = 16'h0C80;
    wr_q = '{8'h00};
    do_write(8'h90, 1'b0);
    do_read(8'h91, 2);
    check("temp_msb", rd_got[0], 8'h0C);
    check("temp_lsb", rd_got[1], 8'h80);

    // foreign address: no ACK, no register change
    sda_low = 0;
    wr_q = '{8'h03, 8'h55};
    do_write(8'h94, 1'b1);
    check("no_ack_drive", sda_low, 0);
    check("cfg_untouched", config_o, 8'h00);

    // software reset via pointer 0x2F
    wr_q = '{8'h0A, 8'h0F};
    do_write(8'h90, 1'b1);
    check("hyst_0f", t_hyst_o, 8'h0F);
    sw0 = d_sw_cnt;
    wr_q = '{8'h2F};
    do_write(8'h90, 1'b1);
    check("sw_rst_pulse", d_sw_cnt - sw0, 1);
    check("hyst_def", t_hyst_o, 8'h05);
    check("high_def", t_high_o, 16'h2000);
    check("ptr_2f", dbg_ptr_o, 8'h2F);

    // snapshot coherence across MSB/LSB
    wr_q = '{8'h00};
    do_write(8'h90, 1'b0);
    temperature_i = 16'h0C80;
    temp_new = 16'h0D00;
    change_temp = 1'b1;
    do_read(8'h91, 2);
    change_temp = 1'b0;
    check("snap_msb", rd_got[0], 8'h0C);
    check("snap_lsb", rd_got[1], 8'h80);

    // ID register then unmapped
    wr_q = '{8'h0B};
    do_write(8'h90, 1'b0);
    do_read(8'h91, 2);
    check("id_cb", rd_got[0], 8'hCB);
    check("unmapped_00", rd_got[1], 8'h00);

    // reset while the target drives bit 3 (0) of 0xCB
    wr_q = '{8'h0B};
    do_write(8'h90, 1'b0);
    i2c_start();
    send_byte(8'h91, ackn);
    check("addr_ack_rst", ackn, 1'b0);
    rd_bit(bv);
    rd_bit(bv);
    m_sda = 1'b1;
    wq();
    check("bit3_driven_low", bus_if.SDA_t, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_release_sda", bus_if.SDA_t, 1'b1);
    check("rst_busy_mid", busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    m_reset_all();
    m_scl = 1'b1; wq(); m_scl = 1'b0; wq();
    i2c_stop();
    settle();

    // randomized traffic
    for (int it = 0; it < 20; it++) begin
      address_bits = 2'($urandom_range(0, 3));
      temperature_i = 16'($urandom);
      a2 = address_bits;
      if ($urandom_range(0, 4) == 0) a2 = address_bits ^ 2'($urandom_range(1, 3));
      abyte = {5'b10010, a2, 1'b0};
      if ($urandom_range(0, 9) == 0) abyte = 8'($urandom) & 8'hFE;
      kind = $urandom_range(0, 3);
      n = $urandom_range(1, 3);
      if (kind <= 1) begin
        wr_q = '{pick_ptr()};
        for (int k = 0; k < n; k++) wr_q.push_back(8'($urandom));
        do_write(abyte, 1'b1);
      end else if (kind == 2) begin
        wr_q = '{pick_ptr()};
        do_write(abyte, 1'b0);
        do_read(abyte | 8'h01, n);
      end else begin
        do_read(abyte | 8'h01, n);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
